unit_nxm: RTL

- Parametrised bitnet unit with NUM_IN binary inputs, NUM_OUT binary outputs and a full NUM_OUT x NUM_IN matrix of 1-bit weights.
- Forward path computes an XNOR-majority per output. Backward path computes an XNOR-majority per input.
- Each weight owns a saturating gradient counter that flips the weight when the counter reaches a threshold.
- Drop-in successor unit for arbitrary fan-in/fan-out layers.

---
 rtl/unit_nxm_pkg.sv | 46 ++++
 rtl/unit_nxm_if.sv | 38 +++
 rtl/unit_nxm_grad_counter.sv | 50 +++++
 rtl/unit_nxm.sv | 111 +++++++++++
 4 files changed

// File: rtl/unit_nxm_pkg.sv
// Shared helpers for the bitnet unit.
//   popcount  - ones count over the low 'len' bits of a MAX_W vector
//   majority  - 1 if more than half of 'len' bits are set, osc on an exact tie
//   w_idx_t   - (row, col) weight coordinate; w_flat_idx maps it to the
//               flat weights_out bit position row*NUM_IN+col
package bitnet_unit_pkg;

  // Widest fan-in/fan-out the helper functions accept.
  localparam int MAX_W    = 64;
  // Counter width: wide enough for MAX_W, plus one bit of headroom.
  localparam int PC_MAX_W = $clog2(MAX_W + 1) + 1;
  localparam logic [PC_MAX_W-1:0] PC_ONE = PC_MAX_W'(1);

  typedef struct packed {
    logic [15:0] row;
    logic [15:0] col;
  } w_idx_t;

  function automatic int unsigned w_flat_idx(input w_idx_t idx, input int unsigned num_in);
    return int'(idx.row) * num_in + int'(idx.col);
  endfunction

  function automatic logic [PC_MAX_W-1:0] popcount(input logic [MAX_W-1:0] v,
                                                   input int unsigned    len);
    logic [PC_MAX_W-1:0] c;
    c = '0;
    for (int unsigned k = 0; k < MAX_W; k++) begin
      if (k < len && v[k]) c = c + PC_ONE;
    end
    return c;
  endfunction

  // Compare 2*count against len so odd and even lengths share one rule.
  function automatic logic majority(input logic [MAX_W-1:0] v,
                                    input int unsigned    len,
                                    input logic           osc);
    logic [PC_MAX_W:0] twice;
    logic [PC_MAX_W:0] n;
    twice = {popcount(v, len), 1'b0};
    n     = (PC_MAX_W + 1)'(len);
    if (twice > n)       return 1'b1;
    else if (twice == n) return osc;
    else                 return 1'b0;
  endfunction

endpackage

// File: rtl/unit_nxm_if.sv
// Bus bundle of the bitnet unit.
//   master: drives oscillator, fd_prop, bk_prop, fin, bin (and, with
//           UNIT_NXM_WLOAD_EN defined, w_load / w_load_data); reads
//           fout, bout, weights_out.
//   slave : the unit itself (mirror directions).
interface unit_nxm_if #(
  parameter int NUM_IN  = 3,
  parameter int NUM_OUT = 2
);
  logic                       oscillator;
  logic                       fd_prop;
  logic                       bk_prop;
  logic [NUM_IN-1:0]          fin;
  logic [NUM_OUT-1:0]         bin;
  logic [NUM_OUT-1:0]         fout;
  logic [NUM_IN-1:0]          bout;
  logic [NUM_OUT*NUM_IN-1:0]  weights_out;
`ifdef UNIT_NXM_WLOAD_EN
  logic                       w_load;
  logic [NUM_OUT*NUM_IN-1:0]  w_load_data;
`endif

  modport master (
    output oscillator, fd_prop, bk_prop, fin, bin,
`ifdef UNIT_NXM_WLOAD_EN
    output w_load, w_load_data,
`endif
    input  fout, bout, weights_out
  );

  modport slave (
    input  oscillator, fd_prop, bk_prop, fin, bin,
`ifdef UNIT_NXM_WLOAD_EN
    input  w_load, w_load_data,
`endif
    output fout, bout, weights_out
  );
endinterface

// File: rtl/unit_nxm_grad_counter.sv
// Per-weight gradient counter (module grad_counter).
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   en               : backward strobe, counter/weight only move when high
//   disagree         : prediction differs from the target this cycle
//   load_clr         : bulk weight load; forces w <= load_data, count <= 0
//   load_data        : weight value taken on load_clr
//   w                : the weight bit
//   count            : saturating disagreement count, never reaches THRESH
module grad_counter #(
  parameter int   CNT_W  = 4,
  parameter int   THRESH = 4,
  parameter logic W_INIT = 1'b0
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             en,
  input  logic             disagree,
  input  logic             load_clr,
  input  logic             load_data,
  output logic             w,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W:0]   THR = (CNT_W + 1)'(THRESH);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // One extra bit so the threshold compare cannot alias on wrap.
  logic [CNT_W:0] inc;
  assign inc = {1'b0, count} + {1'b0, ONE};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      w     <= W_INIT;
      count <= '0;
    end else if (load_clr) begin
      w     <= load_data;
      count <= '0;
    end else if (en) begin
      if (disagree) begin
        if (inc == THR) begin
          w     <= ~w;
          count <= '0;
        end else begin
          count <= inc[CNT_W-1:0];
        end
      end else if (count != '0) begin
        count <= count - ONE;
      end
    end
  end
endmodule

// File: rtl/unit_nxm.sv
// Bitnet unit: NUM_IN binary inputs, NUM_OUT binary outputs, a full
// NUM_OUT x NUM_IN matrix of 1-bit weights, each trained by grad_counter.
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   bus (slave)      : oscillator, fd_prop, bk_prop, fin, bin in;
//                      fout, bout, weights_out out (bit j*NUM_IN+i = w[j][i])
// Optional: define UNIT_NXM_WLOAD_EN to add w_load / w_load_data to the bus;
// a load replaces all weights and clears all counters, winning over flips.
module unit_nxm
  import bitnet_unit_pkg::*;
#(
  parameter int   NUM_IN  = 3,
  parameter int   NUM_OUT = 2,
  parameter int   CNT_W   = 4,
  parameter int   THRESH  = 4,
  parameter logic W_INIT  = 1'b0
) (
  input  logic     clk_in,
  input  logic     rst_n_in,
  unit_nxm_if.slave bus
);
  localparam int NW = NUM_OUT * NUM_IN;

  logic [NW-1:0]       w;
  logic [NW*CNT_W-1:0] cnt_flat;   // all counters, for observation
  logic [NUM_IN-1:0]   fin_q;
  logic [NUM_OUT-1:0]  fout_reg, fout_next;
  logic [NUM_IN-1:0]   bout_reg, bout_next;
  logic                wl;
  logic [NW-1:0]       wl_data;

`ifdef UNIT_NXM_WLOAD_EN
  assign wl      = bus.w_load;
  assign wl_data = bus.w_load_data;
`else
  assign wl      = 1'b0;
  assign wl_data = '0;
`endif

  genvar gi, gj;

  // Forward: XNOR-majority of fin against each weight row.
  generate
    for (gj = 0; gj < NUM_OUT; gj++) begin : g_fwd
      logic [MAX_W-1:0] agree_vec;
      always_comb begin
        agree_vec = '0;
        for (int k = 0; k < NUM_IN; k++)
          agree_vec[k] = bus.fin[k] ~^ w[gj*NUM_IN + k];
      end
      assign fout_next[gj] = majority(agree_vec, NUM_IN, bus.oscillator);
    end
  endgenerate

  // Backward: XNOR-majority of bin against each weight column.
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_bwd
      logic [MAX_W-1:0] agree_vec;
      always_comb begin
        agree_vec = '0;
        for (int k = 0; k < NUM_OUT; k++)
          agree_vec[k] = bus.bin[k] ~^ w[k*NUM_IN + gi];
      end
      assign bout_next[gi] = majority(agree_vec, NUM_OUT, bus.oscillator);
    end
  endgenerate

  // Gradient: prediction uses the latched fin_q so a simultaneous fd_prop
  // capture does not leak into this cycle's update.
  generate
    for (gj = 0; gj < NUM_OUT; gj++) begin : g_row
      for (gi = 0; gi < NUM_IN; gi++) begin : g_col
        localparam w_idx_t      IDX = '{row: 16'(gj), col: 16'(gi)};
        localparam int unsigned B   = w_flat_idx(IDX, NUM_IN);
        logic pred;
        assign pred = fin_q[gi] ~^ w[B];
        grad_counter #(
          .CNT_W (CNT_W),
          .THRESH(THRESH),
          .W_INIT(W_INIT)
        ) u_gc (
          .clk_in   (clk_in),
          .rst_n_in (rst_n_in),
          .en       (bus.bk_prop),
          .disagree (pred != bus.bin[gj]),
          .load_clr (wl),
          .load_data(wl_data[B]),
          .w        (w[B]),
          .count    (cnt_flat[B*CNT_W +: CNT_W])
        );
      end
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fout_reg <= '0;
      bout_reg <= '0;
      fin_q    <= '0;
    end else begin
      if (bus.fd_prop) begin
        fout_reg <= fout_next;
        fin_q    <= bus.fin;
      end
      if (bus.bk_prop) bout_reg <= bout_next;
    end
  end

  assign bus.fout        = fout_reg;
  assign bus.bout        = bout_reg;
  assign bus.weights_out = w;
endmodule
